evm_vote_controller: RTL
========================

Name: evm_vote_controller

Overview:
- Ballot sequencer for the EVM datapath: one officer authorization (master_enable) permits exactly one vote.
- Validates the party button press, issues a single-cycle increment strobe with a party index to the per-party vote counters, and locks out further presses until the ballot completes.
- Handles poll closing: gates the result mux (select s, 4-bit mux_out) so tallies are readable only after close.
- Sits between the raw button/officer inputs and the counter + result-mux datapath.

Parameters:
- TIMEOUT_CYCLES, 1000: cycles an armed ballot waits for a press before being cancelled; minimum 2.
- CNT_W, 8: width of the total-ballot counter, which saturates.

Ports:
- clk  in  1  system clock, rising-edge.
- reset_n  in  1  asynchronous active-low reset.
- master_enable  in  1  officer authorize; the rising edge arms one ballot.
- btn  in  4  party buttons, btn[0]=a, btn[1]=b, btn[2]=c, btn[3]=d; level, active-high.
- close_poll  in  1  level; when sampled high, the poll closes permanently until reset.
- vote_valid  out  1  one-cycle increment strobe to the counters.
- vote_sel  out  2  party index (0=a..3=d); meaningful only when vote_valid=1.
- armed  out  1  high while a ballot is authorized and awaiting a press.
- invalid_press  out  1  one-cycle pulse when more than one button is pressed while armed.
- timeout  out  1  one-cycle pulse when an armed ballot expires.
- ballot_count  out  CNT_W  total accepted votes, saturating.
- result_en  out  1  high only in CLOSED; enables the result mux output.

Behaviour:
- All inputs are synchronous to clk (synchronizers live upstream).
- Reset (asynchronous, any state):
  - state=IDLE; all outputs 0; ballot_count=0; timeout counter=0.
  - The master_enable edge register is cleared to 0, so a level already high at reset release does not arm.
- States: IDLE, WREL, ARMED, CAST, LOCK, CLOSED. Transitions:
  - IDLE: a master_enable rising edge (me & ~me_q) goes to WREL if btn!=0, else to ARMED.
  - WREL: waits for btn==0 before accepting a press, so a pre-held button cannot vote; then goes to ARMED. The timeout counter runs here too.
  - ARMED: armed=1; the timeout counter increments each cycle.
    - btn one-hot: latch the index into vote_sel and go to CAST.
    - btn with 2 or more bits set: invalid_press=1 for one cycle, go to WREL. The ballot stays authorized and the timeout counter is not reset.
    - Counter reaches TIMEOUT_CYCLES-1 with no valid press: timeout=1 for one cycle, go to IDLE. A valid press in that same cycle wins; no timeout.
  - CAST: vote_valid=1 for exactly one cycle; ballot_count increments, holding at 2^CNT_W-1 when saturated; go to LOCK.
  - LOCK: waits for btn==0, then goes to IDLE. master_enable edges are ignored in WREL/ARMED/CAST/LOCK and are not queued.
- Latency: a one-hot press sampled at edge N is registered in state CAST at edge N+1, so vote_valid is high N+1..N+2. armed drops at edge N+1.
- close_poll:
  - Sampled in IDLE/WREL/ARMED/LOCK: go to CLOSED next cycle. An in-progress armed ballot is cancelled with no vote and no timeout pulse.
  - In CAST: the vote completes first (vote_valid still fires), then CLOSED.
  - CLOSED: result_en=1; btn and master_enable are ignored; the state persists until reset_n.
- armed=1 in WREL and ARMED; 0 otherwise.
- vote_sel holds its last value outside CAST.

Decomposition:
- Shared package evm_pkg: state enum encoding (3-bit), party index constants PARTY_A..PARTY_D, and the NUM_PARTIES=4 constant, all reused by the counter and mux blocks.
- One natural sub-module, evm_onehot_check: combinational, 4-bit in; outputs onehot, multi and a 2-bit index. Used by the controller and reusable in the bench scoreboard.

Test Plan:
- Reset, master_enable pulse, btn=4'b0001 for 3 cycles, then release:
  - exactly one vote_valid with vote_sel=0; ballot_count=1; armed low after the press; returns to IDLE.
- Arm, btn=4'b0101, then btn=0, then btn=4'b0100:
  - invalid_press pulses once;
  - then vote_valid with vote_sel=2; ballot_count=1.
- Hold btn=4'b1000 across the master_enable edge, keep it held 5 cycles, release, press btn=4'b0010:
  - no vote for d; a single vote with vote_sel=1.
- TIMEOUT_CYCLES=8: arm, no press:
  - timeout pulses once, 8 cycles after arming; armed=0; ballot_count unchanged.
  - A second master_enable pulse during LOCK produces no extra ballot.
- Arm, assert close_poll before any press:
  - no vote_valid; result_en=1 next cycle and stays high;
  - later btn/master_enable activity is ignored; reset_n low clears result_en.
- CNT_W=2: four complete ballots (a, c, d, a):
  - ballot_count saturates at 3 and stays there; vote_valid still fires each time.

Source files
------------

// File: rtl/evm_pkg.sv
// Shared definitions for the EVM datapath: controller state encoding and party indices.
package evm_pkg;

  localparam int unsigned NUM_PARTIES = 4;
  localparam int unsigned PARTY_W     = 2;

  localparam logic [PARTY_W-1:0] PARTY_A = 2'd0;
  localparam logic [PARTY_W-1:0] PARTY_B = 2'd1;
  localparam logic [PARTY_W-1:0] PARTY_C = 2'd2;
  localparam logic [PARTY_W-1:0] PARTY_D = 2'd3;

  // Ballot sequencer states; the 3-bit encoding is shared with the counter/mux blocks.
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StWrel   = 3'd1,
    StArmed  = 3'd2,
    StCast   = 3'd3,
    StLock   = 3'd4,
    StClosed = 3'd5
  } evm_state_e;

endpackage

// File: rtl/evm_onehot_check.sv
// Classifies the party button vector: exactly one pressed, several pressed, and the
// index of the pressed button when exactly one is down.
module evm_onehot_check
  import evm_pkg::*;
(
  input  logic [NUM_PARTIES-1:0] btn_i,
  output logic                   onehot_o,
  output logic                   multi_o,
  output logic [PARTY_W-1:0]     idx_o
);

  logic [2:0] ones;

  // Population count and index decode.
  always_comb begin
    ones = '0;
    for (int i = 0; i < NUM_PARTIES; i++) begin
      ones = ones + 3'(btn_i[i]);
    end
    onehot_o = (ones == 3'd1);
    multi_o  = (ones > 3'd1);
    idx_o    = PARTY_A;
    unique case (btn_i)
      4'b0001: idx_o = PARTY_A;
      4'b0010: idx_o = PARTY_B;
      4'b0100: idx_o = PARTY_C;
      4'b1000: idx_o = PARTY_D;
      default: idx_o = PARTY_A;
    endcase
  end

endmodule

// File: rtl/evm_vote_controller.sv
// Ballot sequencer: one officer authorization permits exactly one vote, with
// button-release interlocks, an arming timeout and permanent poll closing.
module evm_vote_controller
  import evm_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000, // must be at least 2
  parameter int unsigned CNT_W          = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   master_enable,
  input  logic [NUM_PARTIES-1:0] btn,
  input  logic                   close_poll,
  output logic                   vote_valid,
  output logic [PARTY_W-1:0]     vote_sel,
  output logic                   armed,
  output logic                   invalid_press,
  output logic                   timeout,
  output logic [CNT_W-1:0]       ballot_count,
  output logic                   result_en
);

  localparam int unsigned       TmoW    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TmoW-1:0]   TmoLast = TmoW'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CntMax  = {CNT_W{1'b1}};

  evm_state_e           state_q, state_d;
  logic                 me_q;
  logic [TmoW-1:0]      tmo_cnt_q, tmo_cnt_d;
  logic [PARTY_W-1:0]   sel_q, sel_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 tmo_pulse_q, tmo_pulse_d;
  logic                 inv_q, inv_d;

  logic                 me_rise;
  logic                 btn_any;
  logic                 btn_onehot;
  logic                 btn_multi;
  logic [PARTY_W-1:0]   btn_idx;

  evm_onehot_check u_onehot_check (
    .btn_i    (btn),
    .onehot_o (btn_onehot),
    .multi_o  (btn_multi),
    .idx_o    (btn_idx)
  );

  assign me_rise = master_enable & ~me_q;
  assign btn_any = |btn;

  // State, counters and registered pulse outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      me_q        <= 1'b0;
      tmo_cnt_q   <= '0;
      sel_q       <= PARTY_A;
      count_q     <= '0;
      tmo_pulse_q <= 1'b0;
      inv_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      me_q        <= master_enable;
      tmo_cnt_q   <= tmo_cnt_d;
      sel_q       <= sel_d;
      count_q     <= count_d;
      tmo_pulse_q <= tmo_pulse_d;
      inv_q       <= inv_d;
    end
  end

  // Next-state logic; close_poll outranks everything except a vote already in CAST.
  always_comb begin
    state_d     = state_q;
    tmo_cnt_d   = tmo_cnt_q;
    sel_d       = sel_q;
    count_d     = count_q;
    tmo_pulse_d = 1'b0;
    inv_d       = 1'b0;
    unique case (state_q)
      StIdle: begin
        tmo_cnt_d = '0;
        if (close_poll) begin
          state_d = StClosed;
        end else if (me_rise) begin
          // A button already held at authorization must be released first.
          state_d = btn_any ? StWrel : StArmed;
        end
      end
      StWrel: begin
        tmo_cnt_d = tmo_cnt_q + TmoW'(1);
        if (close_poll) begin
          state_d = StClosed;
        end else if (tmo_cnt_q == TmoLast) begin
          tmo_pulse_d = 1'b1;
          state_d     = StIdle;
        end else if (!btn_any) begin
          state_d = StArmed;
        end
      end
      StArmed: begin
        tmo_cnt_d = tmo_cnt_q + TmoW'(1);
        if (close_poll) begin
          state_d = StClosed;
        end else if (btn_onehot) begin
          // A valid press on the last cycle still beats the timeout.
          sel_d   = btn_idx;
          state_d = StCast;
        end else if (tmo_cnt_q == TmoLast) begin
          tmo_pulse_d = 1'b1;
          state_d     = StIdle;
        end else if (btn_multi) begin
          // Ballot stays authorized; timeout keeps running from where it was.
          inv_d   = 1'b1;
          state_d = StWrel;
        end
      end
      StCast: begin
        if (count_q != CntMax) begin
          count_d = count_q + CNT_W'(1);
        end
        state_d = close_poll ? StClosed : StLock;
      end
      StLock: begin
        if (close_poll) begin
          state_d = StClosed;
        end else if (!btn_any) begin
          state_d = StIdle;
        end
      end
      StClosed: begin
        state_d = StClosed;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Moore outputs decoded from the state register.
  always_comb begin
    vote_valid    = (state_q == StCast);
    armed         = (state_q == StWrel) || (state_q == StArmed);
    result_en     = (state_q == StClosed);
    vote_sel      = sel_q;
    ballot_count  = count_q;
    invalid_press = inv_q;
    timeout       = tmo_pulse_q;
  end

endmodule
